axi_rdata_router: RTL and testbench

//  Return-path router for the shared slave read-data (R) channel. The address arbiter tags

---
 rtl/axi_rdata_router_if.sv | 51 +++++
 rtl/axi_rdata_router.sv | 146 ++++++++++++++
 tb/tb_axi_rdata_router.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rdata_router_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_rdata_router_if
//  Brief    : Shared slave R channel plus the two routed master R channels.
//  Revision : 1.0 - initial release
// ============================================================================
interface axi_rdata_router_if #(
    parameter int ID_BITS   = 4,
    parameter int DATA_BITS = 32
);
    logic [ID_BITS+3:0]   RID_S;
    logic [DATA_BITS-1:0] RDATA_S;
    logic [1:0]           RRESP_S;
    logic                 RLAST_S;
    logic                 RVALID_S;
    logic                 RREADY_S;

    logic [ID_BITS-1:0]   RID_M0;
    logic [DATA_BITS-1:0] RDATA_M0;
    logic [1:0]           RRESP_M0;
    logic                 RLAST_M0;
    logic                 RVALID_M0;
    logic                 RREADY_M0;

    logic [ID_BITS-1:0]   RID_M1;
    logic [DATA_BITS-1:0] RDATA_M1;
    logic [1:0]           RRESP_M1;
    logic                 RLAST_M1;
    logic                 RVALID_M1;
    logic                 RREADY_M1;

    // slave: the router's view; master: the surrounding fabric's view
    modport slave (
        input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        output RREADY_S,
        output RID_M0, RDATA_M0, RRESP_M0, RLAST_M0, RVALID_M0,
        input  RREADY_M0,
        output RID_M1, RDATA_M1, RRESP_M1, RLAST_M1, RVALID_M1,
        input  RREADY_M1
    );

    modport master (
        output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        input  RREADY_S,
        input  RID_M0, RDATA_M0, RRESP_M0, RLAST_M0, RVALID_M0,
        output RREADY_M0,
        input  RID_M1, RDATA_M1, RRESP_M1, RLAST_M1, RVALID_M1,
        output RREADY_M1
    );
endinterface
`default_nettype wire

// File: rtl/axi_rdata_router.sv
`default_nettype none
// ============================================================================
//  Module   : axi_rdata_router
//  Brief    : Tag-decoding R-channel return router with burst lock and 2-deep FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_rdata_router #(
    parameter int ID_BITS   = 4,
    parameter int DATA_BITS = 32
) (
    input  logic                clk,
    input  logic                rst,
    axi_rdata_router_if.slave   bus,
    output logic                err_tag,
    output logic                err_intlv
);
    localparam int c_SID_BITS = ID_BITS + 4;
    localparam int c_ENT_BITS = c_SID_BITS + DATA_BITS + 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOCK_M0 = 2'd1,
        S_LOCK_M1 = 2'd2,
        S_DROP    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [c_ENT_BITS-1:0]   mem_q [2];
    logic                    wr_ptr_q, rd_ptr_q;
    logic [1:0]              count_q, count_d;
    logic                    err_tag_q, err_tag_d;
    logic                    err_intlv_q, err_intlv_d;

    logic                    w_full, w_empty, w_push, w_pop, w_act;
    logic [c_ENT_BITS-1:0]   w_head;
    logic [c_SID_BITS-1:0]   w_head_id;
    logic [DATA_BITS-1:0]    w_head_data;
    logic [1:0]              w_head_resp;
    logic                    w_head_last;
    logic [3:0]              w_tag;
    logic                    w_tag_m0, w_tag_m1;
    logic                    w_sel_m0, w_sel_m1, w_sel_drop;
    logic                    w_v0, w_v1;

    always_comb begin
        w_full      = (count_q == 2'd2);
        w_empty     = (count_q == 2'd0);
        w_push      = bus.RVALID_S & ~w_full & ~rst;
        w_head      = mem_q[rd_ptr_q];
        w_head_id   = w_head[c_ENT_BITS-1 -: c_SID_BITS];
        w_head_data = w_head[DATA_BITS+2:3];
        w_head_resp = w_head[2:1];
        w_head_last = w_head[0];
        w_tag       = w_head_id[c_SID_BITS-1 -: 4];
        w_tag_m0    = (w_tag == 4'b0001);
        w_tag_m1    = (w_tag == 4'b0010);

        // Locked states ignore the head tag so a whole burst stays on one master
        w_sel_m0   = 1'b0;
        w_sel_m1   = 1'b0;
        w_sel_drop = 1'b0;
        case (state_q)
            S_IDLE: begin
                w_sel_m0   = w_tag_m0;
                w_sel_m1   = w_tag_m1;
                w_sel_drop = ~w_tag_m0 & ~w_tag_m1;
            end
            S_LOCK_M0: w_sel_m0   = 1'b1;
            S_LOCK_M1: w_sel_m1   = 1'b1;
            default:   w_sel_drop = 1'b1;
        endcase

        w_act = ~w_empty & ~rst;
        w_v0  = w_act & w_sel_m0;
        w_v1  = w_act & w_sel_m1;
        w_pop = (w_v0 & bus.RREADY_M0) | (w_v1 & bus.RREADY_M1) | (w_act & w_sel_drop);

        state_d = state_q;
        if (w_pop) begin
            if (w_head_last) begin
                state_d = S_IDLE;
            end else if (state_q == S_IDLE) begin
                if (w_sel_m0) begin
                    state_d = S_LOCK_M0;
                end else if (w_sel_m1) begin
                    state_d = S_LOCK_M1;
                end else begin
                    state_d = S_DROP;
                end
            end
        end

        count_d = count_q;
        if (w_push & ~w_pop) begin
            count_d = count_q + 2'd1;
        end else if (~w_push & w_pop) begin
            count_d = count_q - 2'd1;
        end

        err_tag_d   = err_tag_q | (w_pop & w_sel_drop);
        err_intlv_d = err_intlv_q | (w_pop & (((state_q == S_LOCK_M0) & ~w_tag_m0) |
                                               ((state_q == S_LOCK_M1) & ~w_tag_m1)));
    end

    always_comb begin
        bus.RREADY_S  = ~w_full & ~rst;
        bus.RVALID_M0 = w_v0;
        bus.RID_M0    = w_v0 ? w_head_id[ID_BITS-1:0] : '0;
        bus.RDATA_M0  = w_v0 ? w_head_data : '0;
        bus.RRESP_M0  = w_v0 ? w_head_resp : 2'b00;
        bus.RLAST_M0  = w_v0 & w_head_last;
        bus.RVALID_M1 = w_v1;
        bus.RID_M1    = w_v1 ? w_head_id[ID_BITS-1:0] : '0;
        bus.RDATA_M1  = w_v1 ? w_head_data : '0;
        bus.RRESP_M1  = w_v1 ? w_head_resp : 2'b00;
        bus.RLAST_M1  = w_v1 & w_head_last;
        err_tag       = err_tag_q & ~rst;
        err_intlv     = err_intlv_q & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            err_tag_q   <= 1'b0;
            err_intlv_q <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            err_tag_q   <= err_tag_d;
            err_intlv_q <= err_intlv_d;
            if (w_push) begin
                mem_q[wr_ptr_q] <= {bus.RID_S, bus.RDATA_S, bus.RRESP_S, bus.RLAST_S};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi_rdata_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_rdata_router
//  Brief    : Directed bench with a queue-based reference model for the R router.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rdata_router;
    localparam int ID_BITS   = 4;
    localparam int DATA_BITS = 32;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_tag, err_intlv;
    always #5 clk = ~clk;

    axi_rdata_router_if #(.ID_BITS(ID_BITS), .DATA_BITS(DATA_BITS)) bus ();

    axi_rdata_router #(.ID_BITS(ID_BITS), .DATA_BITS(DATA_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_tag   (err_tag),
        .err_intlv (err_intlv)
    );

    int         total = 0;
    int         bad   = 0;
    beat_t      mq[$];
    int         owner = -1;          // -1: no burst open, 0/1: master, 2: discard
    logic       m_etag  = 1'b0;
    logic       m_eintl = 1'b0;
    int         del0 = 0;
    int         del1 = 0;
    logic [3:0] rid0_seen = 4'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: a beat queue plus a burst owner, applied at each negedge for the next edge
    always @(negedge clk) begin : cmp
        beat_t h;
        int    r;
        logic  pop;
        logic  exp_rdy;
        if (rst) begin
            chk("rst_rready_s", bus.RREADY_S, 0);
            chk("rst_rvalid_m0", bus.RVALID_M0, 0);
            chk("rst_rvalid_m1", bus.RVALID_M1, 0);
            chk("rst_fields", {bus.RID_M0, bus.RDATA_M0, bus.RRESP_M0, bus.RLAST_M0}, 0);
            chk("rst_fields_m1", {bus.RID_M1, bus.RDATA_M1, bus.RRESP_M1, bus.RLAST_M1}, 0);
            chk("rst_err", {err_tag, err_intlv}, 0);
            mq.delete();
            owner   = -1;
            m_etag  = 1'b0;
            m_eintl = 1'b0;
        end else begin
            exp_rdy = (mq.size() < 2);
            r   = -1;
            pop = 1'b0;
            h   = '{id: 8'h0, data: 32'h0, resp: 2'b0, last: 1'b0};
            if (mq.size() > 0) begin
                h = mq[0];
                if (owner >= 0)          r = owner;
                else if (h.id[7:4] == 4'd1) r = 0;
                else if (h.id[7:4] == 4'd2) r = 1;
                else                     r = 2;
            end
            chk("rready_s", bus.RREADY_S, exp_rdy);
            chk("rvalid_m0", bus.RVALID_M0, r == 0);
            chk("rvalid_m1", bus.RVALID_M1, r == 1);
            chk("m0_fields", {bus.RID_M0, bus.RDATA_M0, bus.RRESP_M0, bus.RLAST_M0},
                (r == 0) ? {h.id[3:0], h.data, h.resp, h.last} : 39'h0);
            chk("m1_fields", {bus.RID_M1, bus.RDATA_M1, bus.RRESP_M1, bus.RLAST_M1},
                (r == 1) ? {h.id[3:0], h.data, h.resp, h.last} : 39'h0);
            chk("err_tag", err_tag, m_etag);
            chk("err_intlv", err_intlv, m_eintl);

            if (bus.RVALID_M0 && bus.RREADY_M0) begin
                del0++;
                rid0_seen = bus.RID_M0;
            end
            if (bus.RVALID_M1 && bus.RREADY_M1) del1++;

            if (r == 2) pop = 1'b1;
            if (r == 0 && bus.RREADY_M0) pop = 1'b1;
            if (r == 1 && bus.RREADY_M1) pop = 1'b1;
            if (pop) begin
                if (r == 2) m_etag = 1'b1;
                if ((owner == 0 && h.id[7:4] != 4'd1) || (owner == 1 && h.id[7:4] != 4'd2))
                    m_eintl = 1'b1;
                owner = h.last ? -1 : r;
                void'(mq.pop_front());
            end
            if (bus.RVALID_S && exp_rdy)
                mq.push_back('{id: bus.RID_S, data: bus.RDATA_S, resp: bus.RRESP_S, last: bus.RLAST_S});
        end
    end

    task automatic send(input logic [7:0] id, input logic [31:0] d, input logic last);
        int   n = 0;
        logic acc = 1'b0;
        bus.RID_S    = id;
        bus.RDATA_S  = d;
        bus.RRESP_S  = d[1:0];
        bus.RLAST_S  = last;
        bus.RVALID_S = 1'b1;
        do begin
            @(negedge clk);
            acc = bus.RREADY_S;
            @(posedge clk);
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=no_accept required=accept id=%0h", id);
        end
        #1;
        bus.RVALID_S = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.RID_S = '0; bus.RDATA_S = '0; bus.RRESP_S = '0; bus.RLAST_S = 1'b0;
        bus.RVALID_S = 1'b0; bus.RREADY_M0 = 1'b0; bus.RREADY_M1 = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rready_after_reset", bus.RREADY_S, 1);
        @(posedge clk); #1;

        // 1: four-beat M0 burst at full rate
        bus.RREADY_M0 = 1'b1;
        for (int i = 0; i < 4; i++) send(8'h13, 32'hA000_0000 + i, i == 3);
        idle(4);
        chk("t1_m0_beats", del0, 4);
        chk("t1_m1_beats", del1, 0);
        chk("t1_rid_m0", rid0_seen, 4'h3);

        // 2: M1 burst stalled by the master for three clocks
        send(8'h2A, 32'hB000_0000, 1'b0);
        send(8'h2A, 32'hB000_0001, 1'b1);
        @(negedge clk);
        chk("t2_rready_s_full", bus.RREADY_S, 0);
        chk("t2_rvalid_m1_held", bus.RVALID_M1, 1);
        idle(2);
        bus.RREADY_M1 = 1'b1;
        idle(4);
        chk("t2_m1_beats", del1, 2);

        // 3: single-beat M0 then single-beat M1 back to back
        send(8'h11, 32'hC000_0000, 1'b1);
        send(8'h25, 32'hC000_0001, 1'b1);
        idle(4);
        chk("t3_m0_beats", del0, 5);
        chk("t3_m1_beats", del1, 3);

        // 4: unknown tag burst is discarded, then M0 still works
        for (int i = 0; i < 3; i++) send(8'h47, 32'hD000_0000 + i, i == 2);
        idle(3);
        chk("t4_err_tag", err_tag, 1);
        chk("t4_no_delivery", del0 + del1, 8);
        send(8'h12, 32'hE000_0000, 1'b0);
        send(8'h12, 32'hE000_0001, 1'b1);
        idle(4);
        chk("t4_m0_beats", del0, 7);
        chk("t4_err_tag_held", err_tag, 1);

        // 5: M1-tagged beat in the middle of an M0 burst
        send(8'h15, 32'hF000_0000, 1'b0);
        send(8'h25, 32'hF000_0001, 1'b0);
        send(8'h15, 32'hF000_0002, 1'b1);
        idle(4);
        chk("t5_err_intlv", err_intlv, 1);
        chk("t5_m0_beats", del0, 10);
        chk("t5_m1_beats", del1, 3);

        // 6: reset with a full FIFO in the middle of a burst
        bus.RREADY_M0 = 1'b0;
        send(8'h16, 32'h6000_0000, 1'b0);
        send(8'h16, 32'h6000_0001, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rready_s_in_rst", bus.RREADY_S, 0);
        chk("t6_rvalid_m0_in_rst", bus.RVALID_M0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rready_s_after", bus.RREADY_S, 1);
        chk("t6_fifo_empty", bus.RVALID_M0, 0);
        chk("t6_err_cleared", {err_tag, err_intlv}, 0);
        @(posedge clk); #1;
        bus.RREADY_M0 = 1'b1;
        send(8'h23, 32'h7000_0000, 1'b0);
        send(8'h23, 32'h7000_0001, 1'b1);
        idle(4);
        chk("t6_m1_beats", del1, 5);
        chk("t6_m0_beats", del0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
